// File: rtl/modulo_controle_ula.sv
// Registered ALU control unit: decodes one instruction word per handshake into ALU op,
// shift amount and immediate-select. Define CONTROLE_ULA_MULDIV_EN to decode MUL/DIV as multicycle ops.
module modulo_controle_ula #(
   parameter int unsigned MULDIV_LAT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instrucao,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  control_alu,
   output logic [4:0]  shamt,
   output logic        usa_imediato,
   output logic        ilegal
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MULDIV_LAT > 0) ? (MULDIV_LAT - 1) : 0);
   localparam logic USA_ESPERA = (MULDIV_LAT != 0);

   typedef enum logic [1:0] {
      OCIOSO = 2'd0,
      ESPERA = 2'd1,
      PRONTO = 2'd2
   } estado_t;

   estado_t          estado, prox_estado;
   logic [CNT_W-1:0] contador;
   logic             aceita;

   logic [5:0] opcode, funct;
   logic [3:0] dec_alu;
   logic [4:0] dec_shamt;
   logic       dec_imediato;
   logic       dec_ilegal;
   logic       dec_muldiv;

   assign opcode = instrucao[31:26];
   assign funct  = instrucao[5:0];

   // Instruction decode; anything unrecognised falls through to the illegal defaults
   always_comb begin
      dec_alu      = 4'b0000;
      dec_shamt    = 5'd0;
      dec_imediato = 1'b0;
      dec_ilegal   = 1'b0;
      dec_muldiv   = 1'b0;
      case (opcode)
         6'h00: begin
            case (funct)
               6'h24: dec_alu = 4'b0000;
               6'h25: dec_alu = 4'b0001;
               6'h20: dec_alu = 4'b0010;
               6'h26: dec_alu = 4'b0011;
               6'h22: dec_alu = 4'b0110;
               6'h2A: dec_alu = 4'b0111;
               6'h27: dec_alu = 4'b1100;
               6'h02: begin
                  dec_alu   = 4'b1101;
                  dec_shamt = instrucao[10:6];
               end
               6'h00: begin
                  dec_alu   = 4'b1111;
                  dec_shamt = instrucao[10:6];
               end
`ifdef CONTROLE_ULA_MULDIV_EN
               6'h18: begin
                  dec_alu    = 4'b1000;
                  dec_muldiv = 1'b1;
               end
               6'h1A: begin
                  dec_alu    = 4'b1001;
                  dec_muldiv = 1'b1;
               end
`endif
               default: dec_ilegal = 1'b1;
            endcase
         end
         6'h08, 6'h23, 6'h2B: begin
            dec_alu      = 4'b0010;
            dec_imediato = 1'b1;
         end
         6'h0C: begin
            dec_alu      = 4'b0000;
            dec_imediato = 1'b1;
         end
         6'h0D: begin
            dec_alu      = 4'b0001;
            dec_imediato = 1'b1;
         end
         6'h0E: begin
            dec_alu      = 4'b0011;
            dec_imediato = 1'b1;
         end
         6'h0A: begin
            dec_alu      = 4'b0111;
            dec_imediato = 1'b1;
         end
         6'h04, 6'h05: dec_alu = 4'b0110;
         default: dec_ilegal = 1'b1;
      endcase
   end

   assign aceita = in_valid && in_ready;

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) estado <= OCIOSO;
      else       estado <= prox_estado;
   end

   // Next-state logic
   always_comb begin
      prox_estado = estado;
      case (estado)
         OCIOSO: begin
            if (aceita) prox_estado = (dec_muldiv && USA_ESPERA) ? ESPERA : PRONTO;
         end
         ESPERA: begin
            if (contador == '0) prox_estado = PRONTO;
         end
         PRONTO: begin
            if (out_ready) begin
               if (aceita) prox_estado = (dec_muldiv && USA_ESPERA) ? ESPERA : PRONTO;
               else        prox_estado = OCIOSO;
            end
         end
         default: prox_estado = OCIOSO;
      endcase
   end

   // Handshake outputs follow the state directly
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      if (!reset && (estado == OCIOSO || (estado == PRONTO && out_ready))) in_ready = 1'b1;
      if (estado == PRONTO) out_valid = 1'b1;
   end

   // Control registers load only on accept, so they stay put through ESPERA and back-pressure
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         control_alu  <= 4'b0000;
         shamt        <= 5'd0;
         usa_imediato <= 1'b0;
         ilegal       <= 1'b0;
      end else if (aceita) begin
         control_alu  <= dec_alu;
         shamt        <= dec_shamt;
         usa_imediato <= dec_imediato;
         ilegal       <= dec_ilegal;
      end
   end

   // Multicycle hold counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         contador <= '0;
      end else if (aceita && dec_muldiv && USA_ESPERA) begin
         contador <= CNT_LOAD;
      end else if (estado == ESPERA && contador != '0) begin
         contador <= contador - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_modulo_controle_ula.sv
// Directed self-checking bench for modulo_controle_ula (default MULDIV_LAT = 4).
// Expectations follow CONTROLE_ULA_MULDIV_EN when it is defined for the build.
module tb_modulo_controle_ula;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instrucao;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  control_alu;
   logic [4:0]  shamt;
   logic        usa_imediato;
   logic        ilegal;

   int checks = 0;
   int errors = 0;

   modulo_controle_ula dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .instrucao    (instrucao),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .control_alu  (control_alu),
      .shamt        (shamt),
      .usa_imediato (usa_imediato),
      .ilegal       (ilegal)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [3:0] alu, input logic [4:0] sh,
                           input logic imm, input logic il);
      chk({tag, " control_alu"}, 32'(control_alu), 32'(alu));
      chk({tag, " shamt"}, 32'(shamt), 32'(sh));
      chk({tag, " usa_imediato"}, 32'(usa_imediato), 32'(imm));
      chk({tag, " ilegal"}, 32'(ilegal), 32'(il));
   endtask

   // Offer one word from OCIOSO, expect out_valid exactly one cycle after the accept edge
   task automatic run_vec(input string tag, input logic [31:0] w, input logic [3:0] alu,
                          input logic [4:0] sh, input logic imm, input logic il);
      @(negedge clock);
      in_valid  = 1'b1;
      instrucao = w;
      out_ready = 1'b1;
      #1;
      chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, " out_valid pre"}, 32'(out_valid), 32'd0);
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
      chk_outs(tag, alu, sh, imm, il);
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      instrucao = 32'h0;
      out_ready = 1'b0;

      // Reset state
      #12;
      chk("rst in_ready", 32'(in_ready), 32'd0);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk_outs("rst", 4'b0000, 5'd0, 1'b0, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("post-rst in_ready", 32'(in_ready), 32'd1);

      // R-type sweep, shamt field = 3 everywhere
      run_vec("AND", 32'h0085_18E4, 4'b0000, 5'd0, 1'b0, 1'b0);
      run_vec("OR",  32'h0085_18E5, 4'b0001, 5'd0, 1'b0, 1'b0);
      run_vec("ADD", 32'h0085_18E0, 4'b0010, 5'd0, 1'b0, 1'b0);
      run_vec("XOR", 32'h0085_18E6, 4'b0011, 5'd0, 1'b0, 1'b0);
      run_vec("SUB", 32'h0085_18E2, 4'b0110, 5'd0, 1'b0, 1'b0);
      run_vec("SLT", 32'h0085_18EA, 4'b0111, 5'd0, 1'b0, 1'b0);
      run_vec("NOR", 32'h0085_18E7, 4'b1100, 5'd0, 1'b0, 1'b0);
      run_vec("SRL", 32'h0085_18C2, 4'b1101, 5'd3, 1'b0, 1'b0);
      run_vec("SLL", 32'h0004_3080, 4'b1111, 5'd2, 1'b0, 1'b0);
      run_vec("SLL31", 32'h0004_37C0, 4'b1111, 5'd31, 1'b0, 1'b0);
      run_vec("Rbad", 32'h0085_18FF, 4'b0000, 5'd0, 1'b0, 1'b1);

      // I-type and branches; low bits put 1s in the shamt field, which must be ignored
      run_vec("ADDI", 32'h2000_0005, 4'b0010, 5'd0, 1'b1, 1'b0);
      run_vec("LW",   32'h8C00_07C0, 4'b0010, 5'd0, 1'b1, 1'b0);
      run_vec("SW",   32'hAC00_07C0, 4'b0010, 5'd0, 1'b1, 1'b0);
      run_vec("ANDI", 32'h3000_07C0, 4'b0000, 5'd0, 1'b1, 1'b0);
      run_vec("ORI",  32'h3400_07C0, 4'b0001, 5'd0, 1'b1, 1'b0);
      run_vec("XORI", 32'h3800_07C0, 4'b0011, 5'd0, 1'b1, 1'b0);
      run_vec("SLTI", 32'h2800_07C0, 4'b0111, 5'd0, 1'b1, 1'b0);
      run_vec("BEQ",  32'h1000_07C0, 4'b0110, 5'd0, 1'b0, 1'b0);
      run_vec("BNE",  32'h1400_07C0, 4'b0110, 5'd0, 1'b0, 1'b0);
      run_vec("ILL",  32'hFC00_0000, 4'b0000, 5'd0, 1'b0, 1'b1);

`ifndef CONTROLE_ULA_MULDIV_EN
      run_vec("DIVoff", 32'h0043_001A, 4'b0000, 5'd0, 1'b0, 1'b1);
      run_vec("MULoff", 32'h0043_0018, 4'b0000, 5'd0, 1'b0, 1'b1);
`else
      // MUL: accept at edge N, ESPERA for N+1..N+4, out_valid in N+5
      @(negedge clock);
      in_valid  = 1'b1;
      instrucao = 32'h0043_0018;
      out_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      instrucao = 32'h0085_18E0;
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("MUL wait%0d out_valid", i), 32'(out_valid), 32'd0);
         chk($sformatf("MUL wait%0d in_ready", i), 32'(in_ready), 32'd0);
         chk($sformatf("MUL wait%0d alu", i), 32'(control_alu), 32'b1000);
         @(negedge clock);
      end
      in_valid = 1'b0;
      chk("MUL out_valid", 32'(out_valid), 32'd1);
      chk_outs("MUL", 4'b1000, 5'd0, 1'b0, 1'b0);

      // Reset in the middle of a DIV wait
      @(negedge clock);
      in_valid  = 1'b1;
      instrucao = 32'h0043_001A;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      chk("DIV alu", 32'(control_alu), 32'b1001);
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("rstESP in_ready", 32'(in_ready), 32'd0);
      chk("rstESP out_valid", 32'(out_valid), 32'd0);
      chk_outs("rstESP", 4'b0000, 5'd0, 1'b0, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("rstESP rel in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         chk("rstESP no out_valid", 32'(out_valid), 32'd0);
      end
`endif

      // Back-to-back throughput, then back-pressure on the second word
      @(negedge clock);
      in_valid  = 1'b1;
      instrucao = 32'h0085_18E4;
      out_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      chk("b2b A out_valid", 32'(out_valid), 32'd1);
      chk("b2b A alu", 32'(control_alu), 32'b0000);
      chk("b2b A in_ready", 32'(in_ready), 32'd1);
      instrucao = 32'h0085_18E6;
      @(posedge clock);
      @(negedge clock);
      chk("b2b B out_valid", 32'(out_valid), 32'd1);
      chk("b2b B alu", 32'(control_alu), 32'b0011);
      out_ready = 1'b0;
      instrucao = 32'h3400_0001;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp out_valid", 32'(out_valid), 32'd1);
         chk("bp in_ready", 32'(in_ready), 32'd0);
         chk("bp alu", 32'(control_alu), 32'b0011);
         chk("bp imm", 32'(usa_imediato), 32'd0);
         @(negedge clock);
      end
      out_ready = 1'b1;
      #1;
      chk("bp rel in_ready", 32'(in_ready), 32'd1);
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      chk("bp C out_valid", 32'(out_valid), 32'd1);
      chk_outs("bp C", 4'b0001, 5'd0, 1'b1, 1'b0);
      @(posedge clock);
      @(negedge clock);
      chk("drain out_valid", 32'(out_valid), 32'd0);
      chk("drain in_ready", 32'(in_ready), 32'd1);

      // Reset while PRONTO is being back-pressured
      in_valid  = 1'b1;
      instrucao = 32'h0085_18C2;
      out_ready = 1'b0;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      chk("rstPR pre out_valid", 32'(out_valid), 32'd1);
      reset = 1'b1;
      #1;
      chk("rstPR out_valid", 32'(out_valid), 32'd0);
      chk("rstPR in_ready", 32'(in_ready), 32'd0);
      chk_outs("rstPR", 4'b0000, 5'd0, 1'b0, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("rstPR rel in_ready", 32'(in_ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/modulo_controle_ula.md
# modulo_controle_ula

Registered ALU control unit: accepts one instruction word per valid/ready handshake, decodes opcode/funct into the ALU operation code, shift amount and immediate-select, and presents them to the datapath ALU through an output valid/ready handshake. MUL and DIV are multicycle paths through the combinational ALU, so the unit holds their decoded controls stable for `MULDIV_LAT` cycles before declaring them valid. It sits between instruction fetch/decode and the ALU/operand muxes.

## Interface
- `MULDIV_LAT`, 4, extra hold cycles for MUL/DIV before `out_valid`; legal range 0..15.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `in_valid` input 1: `instrucao` is valid.
- `in_ready` output 1: unit can accept this cycle.
- `instrucao` input 32: opcode = [31:26], funct = [5:0], shamt field = [10:6].
- `out_valid` output 1: decoded controls are valid.
- `out_ready` input 1: consumer takes the controls.
- `control_alu` output 4: ALU operation code.
- `shamt` output 5: shift amount; 0 unless SLL/SRL.
- `usa_imediato` output 1: operand 2 comes from the immediate.
- `ilegal` output 1: opcode/funct not recognised.

## Operation
- States: OCIOSO, ESPERA, PRONTO. Reset enters OCIOSO.
- `in_ready` = !reset && (state==OCIOSO || (state==PRONTO && out_ready)).
- Accept = `in_valid && in_ready`. On accept, all control outputs load from the decoded word.
- R-type, opcode 0x00, with `usa_imediato`=0:
  - funct 0x24 AND→0000; 0x25 OR→0001; 0x20 ADD→0010; 0x26 XOR→0011.
  - funct 0x22 SUB→0110; 0x2A SLT→0111; 0x18 MUL→1000; 0x1A DIV→1001.
  - funct 0x27 NOR→1100; 0x02 SRL→1101; 0x00 SLL→1111.
  - `shamt` = instrucao[10:6] only for SRL/SLL.
- I-type, with `usa_imediato`=1:
  - 0x08 ADDI, 0x23 LW, 0x2B SW→0010.
  - 0x0C ANDI→0000; 0x0D ORI→0001; 0x0E XORI→0011; 0x0A SLTI→0111.
- Branches 0x04 BEQ and 0x05 BNE → 0110, `usa_imediato`=0.
- Anything else: `control_alu`=0000, `shamt`=0, `usa_imediato`=0, `ilegal`=1. An illegal word still completes the handshake with latency 1.
- Transitions:
  - OCIOSO→PRONTO on accept of a non-MUL/DIV word.
  - OCIOSO→ESPERA on accept of MUL/DIV when `MULDIV_LAT`>0. The 4-bit counter loads `MULDIV_LAT`-1.
  - ESPERA decrements the counter; it moves to PRONTO when the counter reaches 0.
  - PRONTO with `out_ready` and no accept → OCIOSO.
  - PRONTO with `out_ready` and accept → PRONTO or ESPERA, per the new word.
- `out_valid` = (state==PRONTO). Outputs stay stable while `out_valid && !out_ready`.
- Controls are held unchanged through ESPERA. The combinational ALU sees stable operands/op for the whole multicycle window.

## Timing
- Reset values: state OCIOSO, counter 0, `out_valid`=0, `in_ready`=0 while reset is high, `control_alu`=0000, `shamt`=0, `usa_imediato`=0, `ilegal`=0.
- Non-MUL/DIV latency: accept edge N → `out_valid` high during cycle N+1.
- MUL/DIV latency: `out_valid` first high in cycle N+1+`MULDIV_LAT`. `in_ready`=0 throughout ESPERA.
- `MULDIV_LAT`=0: MUL/DIV behave as single-cycle.
- Full throughput (one word per cycle) for back-to-back non-MUL/DIV words when `out_ready`=1.
- Back-pressure: with `out_ready`=0 in PRONTO, `in_ready`=0. No word is dropped or overwritten.
- Reset asserted mid-ESPERA or mid-PRONTO: immediate return to reset values. The pending word is discarded.

## Configuration
- `CONTROLE_ULA_MULDIV_EN` defined: MUL/DIV decode as specified and use the ESPERA state.
- Not defined: funct 0x18/0x1A decode as illegal (0000, `ilegal`=1, latency 1). ESPERA is never entered, and the counter may be removed.

## Test plan
- Reset mid-stream: assert `reset` during ESPERA → all outputs zero asynchronously; `in_ready`=0 until release, then 1 in OCIOSO.
- Decode sweep with `out_ready`=1:
  - every listed opcode/funct → the exact `control_alu` code, with `out_valid` one cycle after accept.
  - `instrucao`=0x00043080 (SLL, shamt field 2) → 1111, `shamt`=2.
  - 0x2000_0005 (ADDI) → 0010, `usa_imediato`=1.
- MUL with `MULDIV_LAT`=4: accept 0x00430018 at edge N → `control_alu`=1000 from N+1, `out_valid` first high in cycle N+5, `in_ready`=0 for cycles N+1..N+4.
- Back-pressure: hold `out_ready`=0 for 3 cycles with `in_valid`=1 → outputs stable, `in_ready`=0. Release → current word consumed and next word accepted in the same cycle.
- Illegal word 0xFC000000 → `ilegal`=1, `control_alu`=0000, latency 1.
- Build without `CONTROLE_ULA_MULDIV_EN`: funct 0x1A → `ilegal`=1, latency 1.
